// File: rtl/alu_11bit_if.sv
// Operand/result bundle for the 11-bit saturating ALU.
// The master drives operands and the function code; the slave returns the result and flags.
interface alu_11bit_if #(
    parameter int WIDTH = 11
);
    logic signed [WIDTH-1:0] in0;
    logic signed [WIDTH-1:0] in1;
    logic        [3:0]       funct;
    logic signed [WIDTH-1:0] out;
    logic                    overflow;
    logic                    gr_flag;
    logic                    le_flag;
    logic                    eq_flag;

    modport master (
        output in0, in1, funct,
        input  out, overflow, gr_flag, le_flag, eq_flag
    );

    modport slave (
        input  in0, in1, funct,
        output out, overflow, gr_flag, le_flag, eq_flag
    );
endinterface

// File: rtl/alu_11bit.sv
// Saturating signed arithmetic/compare unit for values bounded to +/-MAXVAL.
// Combinational datapath feeding a single registered output stage.
module alu_11bit #(
    parameter int WIDTH  = 11,
    parameter int MAXVAL = 999
) (
    input logic        clk,
    input logic        reset,
    alu_11bit_if.slave bus
);
    typedef enum logic [3:0] {
        ADDMODULE = 4'd0,
        SUBMODULE = 4'd1,
        MULMODULE = 4'd2,
        NOTMODULE = 4'd3,
        DGTMODULE = 4'd4,
        NEGMODULE = 4'd5
    } funct_e;

    // Double width holds the largest product (-1024 * -1024) without wrapping.
    localparam int RW = 2 * WIDTH;
    localparam logic signed [RW-1:0]    MAX_POS = RW'(MAXVAL);
    localparam logic signed [RW-1:0]    MAX_NEG = -MAX_POS;
    localparam logic signed [RW-1:0]    NOT_VAL = RW'(100);
    localparam logic        [WIDTH-1:0] TEN     = WIDTH'(10);
    localparam logic        [WIDTH-1:0] HUNDRED = WIDTH'(100);

    logic signed [RW-1:0]    a_ext;
    logic signed [RW-1:0]    b_ext;
    logic signed [RW-1:0]    res_full;
    logic        [WIDTH-1:0] mag;
    logic        [WIDTH-1:0] digit;
    logic signed [WIDTH-1:0] out_next;
    logic                    ovf_next;

    assign a_ext = {{WIDTH{bus.in0[WIDTH-1]}}, bus.in0};
    assign b_ext = {{WIDTH{bus.in1[WIDTH-1]}}, bus.in1};
    // Unsigned magnitude: |-1024| = 1024 still fits in WIDTH unsigned bits.
    assign mag   = bus.in0[WIDTH-1] ? (~bus.in0 + 1'b1) : bus.in0;

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no path can infer a latch.
        digit = '0;
        if (bus.in1 == WIDTH'(0))
            digit = mag % TEN;
        else if (bus.in1 == WIDTH'(1))
            digit = (mag / TEN) % TEN;
        else if (bus.in1 == WIDTH'(2))
            digit = (mag / HUNDRED) % TEN;
    end

    always_comb begin
        res_full = '0;
        case (bus.funct)
            ADDMODULE: res_full = a_ext + b_ext;
            SUBMODULE: res_full = a_ext - b_ext;
            MULMODULE: res_full = a_ext * b_ext;
            NOTMODULE: res_full = (bus.in0 == '0) ? NOT_VAL : '0;
            DGTMODULE: res_full = {{WIDTH{1'b0}}, digit};
            NEGMODULE: res_full = -a_ext;
            default:   res_full = '0;
        endcase
    end

    always_comb begin
        out_next = res_full[WIDTH-1:0];
        ovf_next = 1'b0;
        if (res_full > MAX_POS) begin
            out_next = MAX_POS[WIDTH-1:0];
            ovf_next = 1'b1;
        end else if (res_full < MAX_NEG) begin
            out_next = MAX_NEG[WIDTH-1:0];
            ovf_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            bus.out      <= '0;
            bus.overflow <= 1'b0;
            bus.gr_flag  <= 1'b0;
            bus.le_flag  <= 1'b0;
            bus.eq_flag  <= 1'b1;
        end else begin
            bus.out      <= out_next;
            bus.overflow <= ovf_next;
            bus.gr_flag  <= bus.in0 > bus.in1;
            bus.le_flag  <= bus.in0 < bus.in1;
            bus.eq_flag  <= bus.in0 == bus.in1;
        end
    end
endmodule

// File: tb/tb_alu_11bit.sv
// Directed self-checking bench for alu_11bit: hand-computed vectors per feature.
module tb_alu_11bit;
    localparam int ADD = 0, SUB = 1, MUL = 2, NOT = 3, DGT = 4, NEG = 5;

    typedef struct {
        int a;
        int b;
        int f;
        int eo;
        int eovf;
        int efl;   // {gr, le, eq}
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   compared = 0;
    int   mismatched = 0;

    alu_11bit_if bus ();

    alu_11bit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int a, input int b, input int f);
        bus.in0   = 11'(a);
        bus.in1   = 11'(b);
        bus.funct = 4'(f);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(5, 7, ADD);
        compared++;
        if (bus.out !== 11'd0 || bus.overflow !== 1'b0 ||
            {bus.gr_flag, bus.le_flag, bus.eq_flag} !== 3'b001) begin
            mismatched++;
            $display("FAIL reset: out=%0d ovf=%b flags=%b, expected out=0 ovf=0 flags=001",
                     $signed(bus.out), bus.overflow, {bus.gr_flag, bus.le_flag, bus.eq_flag});
        end
        step(500, 600, MUL);
        compared++;
        if (bus.out !== 11'd0 || bus.overflow !== 1'b0 ||
            {bus.gr_flag, bus.le_flag, bus.eq_flag} !== 3'b001) begin
            mismatched++;
            $display("FAIL reset_over_mul: out=%0d ovf=%b flags=%b, expected out=0 ovf=0 flags=001",
                     $signed(bus.out), bus.overflow, {bus.gr_flag, bus.le_flag, bus.eq_flag});
        end
        reset = 1'b0;
    endtask

    task automatic test_add_sub();
        vec_t v[11] = '{
            '{200, 4, ADD, 204, 0, 3'b100},
            '{-3, -3, ADD, -6, 0, 3'b001},
            '{999, 0, ADD, 999, 0, 3'b100},
            '{-1000, 1, ADD, -999, 0, 3'b010},
            '{500, 600, ADD, 999, 1, 3'b010},
            '{1023, 1023, ADD, 999, 1, 3'b001},
            '{-999, 0, SUB, -999, 0, 3'b010},
            '{1, 2, SUB, -1, 0, 3'b010},
            '{-1024, 1023, SUB, -999, 1, 3'b010},
            '{1023, -1024, SUB, 999, 1, 3'b100},
            '{10, 10, SUB, 0, 0, 3'b001}
        };
        for (int i = 0; i < 11; i++) begin
            step(v[i].a, v[i].b, v[i].f);
            compared++;
            if (bus.out !== 11'(v[i].eo) || bus.overflow !== 1'(v[i].eovf) ||
                {bus.gr_flag, bus.le_flag, bus.eq_flag} !== 3'(v[i].efl)) begin
                mismatched++;
                $display("FAIL add_sub[%0d]: out=%0d ovf=%b flags=%b, expected out=%0d ovf=%0d flags=%03b",
                         i, $signed(bus.out), bus.overflow, {bus.gr_flag, bus.le_flag, bus.eq_flag},
                         v[i].eo, v[i].eovf, 3'(v[i].efl));
            end
        end
    endtask

    task automatic test_mul();
        vec_t v[8] = '{
            '{200, 4, MUL, 800, 0, 3'b100},
            '{-500, 3, MUL, -999, 1, 3'b010},
            '{-1024, -1, MUL, 999, 1, 3'b010},
            '{1023, 0, MUL, 0, 0, 3'b100},
            '{-1024, 0, MUL, 0, 0, 3'b010},
            '{-1024, -1024, MUL, 999, 1, 3'b001},
            '{-37, 27, MUL, -999, 0, 3'b010},
            '{27, 37, MUL, 999, 0, 3'b010}
        };
        for (int i = 0; i < 8; i++) begin
            step(v[i].a, v[i].b, v[i].f);
            compared++;
            if (bus.out !== 11'(v[i].eo) || bus.overflow !== 1'(v[i].eovf) ||
                {bus.gr_flag, bus.le_flag, bus.eq_flag} !== 3'(v[i].efl)) begin
                mismatched++;
                $display("FAIL mul[%0d]: out=%0d ovf=%b flags=%b, expected out=%0d ovf=%0d flags=%03b",
                         i, $signed(bus.out), bus.overflow, {bus.gr_flag, bus.le_flag, bus.eq_flag},
                         v[i].eo, v[i].eovf, 3'(v[i].efl));
            end
        end
    endtask

    task automatic test_neg_not_dgt();
        vec_t v[14] = '{
            '{5, 0, NEG, -5, 0, 3'b100},
            '{-1024, 0, NEG, 999, 1, 3'b010},
            '{-999, 7, NEG, 999, 0, 3'b010},
            '{1000, 0, NEG, -999, 1, 3'b100},
            '{0, 0, NOT, 100, 0, 3'b001},
            '{5, 0, NOT, 0, 0, 3'b100},
            '{-472, 1, DGT, 7, 0, 3'b010},
            '{-472, 0, DGT, 2, 0, 3'b010},
            '{-472, 2, DGT, 4, 0, 3'b010},
            '{-472, 5, DGT, 0, 0, 3'b010},
            '{-472, -1, DGT, 0, 0, 3'b010},
            '{-1024, 2, DGT, 0, 0, 3'b010},
            '{-1024, 1, DGT, 2, 0, 3'b010},
            '{1023, 0, DGT, 3, 0, 3'b100}
        };
        for (int i = 0; i < 14; i++) begin
            step(v[i].a, v[i].b, v[i].f);
            compared++;
            if (bus.out !== 11'(v[i].eo) || bus.overflow !== 1'(v[i].eovf) ||
                {bus.gr_flag, bus.le_flag, bus.eq_flag} !== 3'(v[i].efl)) begin
                mismatched++;
                $display("FAIL neg_not_dgt[%0d]: out=%0d ovf=%b flags=%b, expected out=%0d ovf=%0d flags=%03b",
                         i, $signed(bus.out), bus.overflow, {bus.gr_flag, bus.le_flag, bus.eq_flag},
                         v[i].eo, v[i].eovf, 3'(v[i].efl));
            end
        end
    endtask

    task automatic test_reserved();
        vec_t v[3] = '{
            '{5, 7, 9, 0, 0, 3'b010},
            '{500, 600, 15, 0, 0, 3'b010},
            '{3, 2, 6, 0, 0, 3'b100}
        };
        for (int i = 0; i < 3; i++) begin
            step(v[i].a, v[i].b, v[i].f);
            compared++;
            if (bus.out !== 11'(v[i].eo) || bus.overflow !== 1'(v[i].eovf) ||
                {bus.gr_flag, bus.le_flag, bus.eq_flag} !== 3'(v[i].efl)) begin
                mismatched++;
                $display("FAIL reserved[%0d]: out=%0d ovf=%b flags=%b, expected out=%0d ovf=%0d flags=%03b",
                         i, $signed(bus.out), bus.overflow, {bus.gr_flag, bus.le_flag, bus.eq_flag},
                         v[i].eo, v[i].eovf, 3'(v[i].efl));
            end
        end
    endtask

    task automatic test_back_to_back();
        step(1, 2, ADD);
        compared++;
        if (bus.out !== 11'sd3 || bus.le_flag !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_add: out=%0d le=%b, expected out=3 le=1", $signed(bus.out), bus.le_flag);
        end
        step(1, 2, SUB);
        compared++;
        if (bus.out !== -11'sd1 || bus.overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_sub: out=%0d ovf=%b, expected out=-1 ovf=0", $signed(bus.out), bus.overflow);
        end
        step(-999, 0, SUB);
        compared++;
        if (bus.out !== 11'h419 || bus.overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_sub_edge: out=%h ovf=%b, expected out=419 ovf=0", bus.out, bus.overflow);
        end
    endtask

    initial begin
        reset     = 1'b0;
        bus.in0   = '0;
        bus.in1   = '0;
        bus.funct = '0;
        @(negedge clk);
        test_reset();
        test_add_sub();
        test_mul();
        test_neg_not_dgt();
        test_reserved();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
